// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between the register block and the buffered UART transmitter.
interface uart_tx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes accepted on a valid/ready handshake are held
// in a FIFO and shifted out LSB first. txd and tx_busy are registered outputs.
module uart_tx_fifo #(
  parameter int ClkFrequency = 200000000,
  parameter int Baud         = 9600,
  parameter int DEPTH        = 16,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_fifo_if.slave   wr,
  output logic            txd,
  output logic            tx_busy,
  output logic [AW:0]     fifo_count
);

  localparam int DIV = ClkFrequency / Baud;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx_fifo: ClkFrequency/Baud must be at least 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          busy_q;
  logic          push, pop;

  // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign wr.wr_ready = ~reset & (count_q != FULL);
  assign push        = wr.wr_valid & wr.wr_ready;
  assign pop         = (state_q == IDLE) & (count_q != '0);

  assign txd        = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;

  // Next FIFO occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // FIFO storage; writes are gated by wr_ready, so reset needs no special case here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr.wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Serializer: txd follows the state one edge later, so every line bit lasts DIV cycles
  // and the idle cycle between frames adds one extra high cycle after the stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      // Busy also covers the popping edge and the final stop-bit edge.
      busy_q <= (count_d != '0) | pop | (state_q != IDLE);
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          txd_q <= 1'b0;
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        DATA: begin
          txd_q <= shift_q[0];
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        STOP: begin
          txd_q <= 1'b1;
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DIV = 8, DEPTH = 16). A timeline model derives
// the expected line, busy flag, occupancy and ready from pushed bytes and frame timing.
module tb_uart_tx_fifo;
  localparam int DIV   = 8;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       txd;
  logic       tx_busy;
  logic [4:0] fifo_count;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.ClkFrequency(800), .Baud(100), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (bus),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         e        = 0;
  int         next_pop = 0;
  bit         act      = 0;
  int         p        = 0;
  logic [7:0] cur      = '0;
  int         accepted = 0;
  logic       exp_txd, exp_busy, exp_ready;
  int         exp_count;

  // One clock: drive inputs, advance the model across the edge, settle to the negedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    bit do_pop, do_push;
    int k;
    bus.wr_valid = v;
    bus.wr_data  = d;
    reset        = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      act      = 0;
      next_pop = e + 1;
    end else begin
      do_pop  = (mq.size() > 0) && (e >= next_pop);
      do_push = v && (mq.size() != DEPTH);
      if (do_pop) begin
        cur      = mq.pop_front();
        act      = 1;
        p        = e;
        next_pop = e + FRAME + 1;
      end
      if (do_push) begin
        mq.push_back(d);
        accepted++;
      end
    end
    @(negedge clk);
    k       = e - (p + 1);
    exp_txd = 1'b1;
    if (act && k >= 0 && k < FRAME) begin
      if (k / DIV == 0) exp_txd = 1'b0;
      else if (k / DIV <= 8) exp_txd = cur[k / DIV - 1];
    end
    exp_busy  = (mq.size() != 0) || (act && e >= p && e <= p + FRAME);
    exp_count = mq.size();
    exp_ready = !r && (mq.size() != DEPTH);
    e++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd); else n_pass++;
      n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else n_pass++;
      n_checks++; if (fifo_count !== 5'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else n_pass++;
      n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.wr_ready); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", bus.wr_ready); else n_pass++;
      n_checks++; if (txd !== 1'b1) $display("FAIL post_reset_txd got %b want 1", txd); else n_pass++;
      n_checks++; if (tx_busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", tx_busy); else n_pass++;
      n_checks++; if (fifo_count !== 5'd0) $display("FAIL post_reset_count got %0d want 0", fifo_count); else n_pass++;
    end
    $display("test_reset done: e=%0d", e);
  endtask

  task automatic test_single();
    cycle(1'b1, 8'h55, 1'b0);
    for (int i = 1; i <= 90; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      n_checks++; if (txd !== exp_txd) $display("FAIL single_txd cyc=%0d got %b want %b", i, txd, exp_txd); else n_pass++;
      n_checks++; if (tx_busy !== exp_busy) $display("FAIL single_busy cyc=%0d got %b want %b", i, tx_busy, exp_busy); else n_pass++;
      if (i == 81) begin
        n_checks++; if (tx_busy !== 1'b1) $display("FAIL single_busy81 got %b want 1", tx_busy); else n_pass++;
      end
      if (i == 82) begin
        n_checks++; if (tx_busy !== 1'b0) $display("FAIL single_busy82 got %b want 0", tx_busy); else n_pass++;
      end
    end
    $display("test_single: byte 0x55 framed, e=%0d", e);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    for (int it = 0; it < 2; it++) begin
      a = (it == 0) ? 8'hA5 : 8'($urandom);
      b = (it == 0) ? 8'h3C : 8'($urandom);
      cycle(1'b1, a, 1'b0);
      cycle(1'b1, b, 1'b0);
      for (int i = 2; i <= 2 * FRAME + 10; i++) begin
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++; if (txd !== exp_txd) $display("FAIL b2b_txd cyc=%0d got %b want %b", i, txd, exp_txd); else n_pass++;
        n_checks++; if (fifo_count !== 5'(exp_count)) $display("FAIL b2b_count cyc=%0d got %0d want %0d", i, fifo_count, exp_count); else n_pass++;
        if (i == 82 || i == 83) begin
          n_checks++;
          if (txd !== ((i == 82) ? 1'b1 : 1'b0)) $display("FAIL b2b_gap cyc=%0d got %b", i, txd); else n_pass++;
        end
      end
      $display("test_back_to_back: bytes 0x%02h 0x%02h, e=%0d", a, b, e);
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((mq.size() != 0 || exp_busy) && guard < 5000) begin
      cycle(1'b0, 8'h00, 1'b0);
      guard++;
      n_checks++; if (txd !== exp_txd) $display("FAIL %s_txd e=%0d got %b want %b", tag, e, txd, exp_txd); else n_pass++;
      n_checks++; if (fifo_count !== 5'(exp_count)) $display("FAIL %s_count e=%0d got %0d want %0d", tag, e, fifo_count, exp_count); else n_pass++;
      n_checks++; if (tx_busy !== exp_busy) $display("FAIL %s_busy e=%0d got %b want %b", tag, e, tx_busy, exp_busy); else n_pass++;
    end
    n_checks++; if (guard >= 5000) $display("FAIL %s_timeout got %0d cycles want <5000", tag, guard); else n_pass++;
  endtask

  task automatic test_fill();
    int dut_acc = 0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      bus.wr_valid = 1'b1;
      #1;
      if (bus.wr_ready === 1'b1) dut_acc++;
      cycle(1'b1, 8'(i), 1'b0);
      n_checks++; if (bus.wr_ready !== exp_ready) $display("FAIL fill_ready cyc=%0d got %b want %b", i, bus.wr_ready, exp_ready); else n_pass++;
      n_checks++; if (fifo_count !== 5'(exp_count)) $display("FAIL fill_count cyc=%0d got %0d want %0d", i, fifo_count, exp_count); else n_pass++;
      if (i >= 16) begin
        n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL fill_full_ready cyc=%0d got %b want 0", i, bus.wr_ready); else n_pass++;
      end
    end
    n_checks++; if (dut_acc != 17) $display("FAIL fill_pushes got %0d want 17", dut_acc); else n_pass++;
    n_checks++; if (accepted != 17) $display("FAIL fill_model_pushes got %0d want 17", accepted); else n_pass++;
    drain("fill");
    n_checks++; if (fifo_count !== 5'd0) $display("FAIL fill_final_count got %0d want 0", fifo_count); else n_pass++;
    $display("test_fill: %0d pushes accepted, e=%0d", dut_acc, e);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 36; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (txd !== 1'b1) $display("FAIL mid_reset_txd got %b want 1", txd); else n_pass++;
    n_checks++; if (fifo_count !== 5'd0) $display("FAIL mid_reset_count got %0d want 0", fifo_count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h81, 1'b0);
    drain("after_reset");
    $display("test_reset_mid: 0x81 sent after truncation, e=%0d", e);
  endtask

  task automatic test_pop_push();
    cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'($urandom), 1'b0);
    n_checks++; if (fifo_count !== 5'd1) $display("FAIL poppush_count got %0d want 1", fifo_count); else n_pass++;
    n_checks++; if (fifo_count !== 5'(exp_count)) $display("FAIL poppush_model got %0d want %0d", fifo_count, exp_count); else n_pass++;
    drain("poppush");
    $display("test_pop_push: simultaneous push/pop, e=%0d", e);
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) == 0);
      cycle(v, 8'($urandom), 1'b0);
      n_checks++; if (txd !== exp_txd) $display("FAIL rand_txd cyc=%0d got %b want %b", i, txd, exp_txd); else n_pass++;
      n_checks++; if (fifo_count !== 5'(exp_count)) $display("FAIL rand_count cyc=%0d got %0d want %0d", i, fifo_count, exp_count); else n_pass++;
      n_checks++; if (tx_busy !== exp_busy) $display("FAIL rand_busy cyc=%0d got %b want %b", i, tx_busy, exp_busy); else n_pass++;
      n_checks++; if (bus.wr_ready !== exp_ready) $display("FAIL rand_ready cyc=%0d got %b want %b", i, bus.wr_ready, exp_ready); else n_pass++;
    end
    drain("rand");
    $display("test_random: done, e=%0d", e);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    reset        = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    test_pop_push();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
